// File: rtl/genesis_gamepads_multi.sv
// rtl/genesis_gamepads_multi.sv - multi-port Genesis pad poller with 8-phase SELECT burst
// Purpose: once per poll period, drive an 8-phase SELECT burst on every pad port,
//          sample the synchronised pins mid-phase, decode a 12-bit button word and
//          confirm the controller type over two consecutive bursts.
// Ports:
//   iCLK             system clock
//   iRESET           asynchronous active-high reset
//   iGENPAD          raw active-low pins, port p at [6p+5:6p] {C/St,B/A,U/Z,D/Y,L/X,R/M}
//   oGENPAD_SELECT   SELECT pin per port (all bits identical)
//   oGENPAD_DECODED  active-high buttons, port p at [12p+11:12p] {Z,Y,X,M,S,C,B,A,U,D,L,R}
//   oGENPAD_TYPE     confirmed type per port: 0 none/SMS, 1 3-button, 2 6-button, 3 inconsistent
//   oVALID           one-cycle strobe when new decoded words are present
module genesis_gamepads_multi #(
    parameter int PORTS        = 2,
    parameter int PHASE_TICKS  = 500,
    parameter int SAMPLE_TICKS = 48,
    parameter int POLL_TICKS   = 1000000
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic [6*PORTS-1:0]   iGENPAD,
    output logic [PORTS-1:0]     oGENPAD_SELECT,
    output logic [12*PORTS-1:0]  oGENPAD_DECODED,
    output logic [2*PORTS-1:0]   oGENPAD_TYPE,
    output logic                 oVALID
);

    localparam int PW = $clog2(POLL_TICKS);
    localparam int TW = $clog2(PHASE_TICKS);

    typedef enum logic [1:0] {IDLE, DRIVE, COMMIT} state_t;

    state_t         state_q, state_d;
    logic [2:0]     k_q, k_d;
    logic [PW-1:0]  poll_q, poll_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [PORTS-1:0] sel_q, sel_d;
    logic           valid_q, valid_d;

    logic [6*PORTS-1:0]  sync1_q, sync2_q;
    // Only the pin bits that feed the decode are kept for phases 0, 4, 5 and 6.
    logic [4*PORTS-1:0]  c0_q, c0_d, c4_q, c4_d, c5_q, c5_d, c6_q, c6_d;
    logic [6*PORTS-1:0]  c1_q, c1_d;
    logic [12*PORTS-1:0] decoded_q, decoded_d;
    logic [2*PORTS-1:0]  type_q, type_d, last_cand_q, last_cand_d;

    logic poll_wrap, tick_end, sample;

    assign poll_wrap = (poll_q == PW'(POLL_TICKS - 1));
    assign tick_end  = (tick_q == TW'(PHASE_TICKS - 1));
    assign sample    = (state_q == DRIVE) && (tick_q == TW'(SAMPLE_TICKS));

    // State register
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= IDLE;
            k_q     <= '0;
            poll_q  <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            poll_q  <= poll_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic; the poll counter free-runs so burst starts stay periodic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tick_d  = tick_q;
        poll_d  = poll_wrap ? '0 : poll_q + PW'(1);
        case (state_q)
            IDLE: begin
                if (poll_wrap) begin
                    state_d = DRIVE;
                    k_d     = 3'd0;
                    tick_d  = '0;
                end
            end
            DRIVE: begin
                if (tick_end) begin
                    tick_d = '0;
                    if (k_q == 3'd7) begin
                        state_d = COMMIT;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: SELECT and the strobe are registered from the next state,
    // so SELECT moves on the very edge that starts a phase.
    always_comb begin
        sel_d   = (state_d == DRIVE) ? {PORTS{k_d[0]}} : {PORTS{1'b1}};
        valid_d = (state_d == COMMIT);
    end

    // Capture, decode and type confirmation; results commit on the edge entering COMMIT.
    always_comb begin
        logic [3:0]  p0, p4, p5, p6;
        logic [5:0]  p1;
        logic [1:0]  cand;
        logic [11:0] word;
        c0_d        = c0_q;
        c1_d        = c1_q;
        c4_d        = c4_q;
        c5_d        = c5_q;
        c6_d        = c6_q;
        decoded_d   = decoded_q;
        type_d      = type_q;
        last_cand_d = last_cand_q;
        p0 = '0; p1 = '0; p4 = '0; p5 = '0; p6 = '0; cand = '0; word = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (sample && k_q == 3'd0) c0_d[4*p +: 4] = {sync2_q[6*p+4 +: 2], sync2_q[6*p +: 2]};
            if (sample && k_q == 3'd1) c1_d[6*p +: 6] = sync2_q[6*p +: 6];
            if (sample && k_q == 3'd4) c4_d[4*p +: 4] = sync2_q[6*p +: 4];
            if (sample && k_q == 3'd5) c5_d[4*p +: 4] = sync2_q[6*p +: 4];
            if (sample && k_q == 3'd6) c6_d[4*p +: 4] = sync2_q[6*p +: 4];

            p0 = c0_q[4*p +: 4];   // {Start, A, Left-low, Right-low}
            p1 = c1_q[6*p +: 6];
            p4 = c4_q[4*p +: 4];
            p5 = c5_q[4*p +: 4];
            p6 = c6_q[4*p +: 4];

            // A 3/6-button pad pulls Left/Right low while SELECT is low; a 6-button
            // pad additionally reads 0000 in phase 4 and 1111 in phase 6.
            if (p0[1:0] != 2'b00)                   cand = 2'd0;
            else if (p4 == 4'h0 && p6 == 4'hF)      cand = 2'd2;
            else if (p4 == 4'h0)                    cand = 2'd3;
            else                                    cand = 2'd1;

            word[3:0]  = ~p1[3:0];
            word[4]    = (cand != 2'd0) ? ~p0[2] : 1'b0;
            word[5]    = ~p1[4];
            word[6]    = ~p1[5];
            word[7]    = (cand != 2'd0) ? ~p0[3] : 1'b0;
            word[11:8] = (cand == 2'd2) ? ~p5 : 4'h0;

            if (valid_d) begin
                decoded_d[12*p +: 12] = word;
                if (cand == last_cand_q[2*p +: 2]) type_d[2*p +: 2] = cand;
                last_cand_d[2*p +: 2] = cand;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            sel_q       <= {PORTS{1'b1}};
            valid_q     <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            c0_q        <= '0;
            c1_q        <= '0;
            c4_q        <= '0;
            c5_q        <= '0;
            c6_q        <= '0;
            decoded_q   <= '0;
            type_q      <= '0;
            last_cand_q <= '0;
        end else begin
            sel_q       <= sel_d;
            valid_q     <= valid_d;
            sync1_q     <= iGENPAD;
            sync2_q     <= sync1_q;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            c4_q        <= c4_d;
            c5_q        <= c5_d;
            c6_q        <= c6_d;
            decoded_q   <= decoded_d;
            type_q      <= type_d;
            last_cand_q <= last_cand_d;
        end
    end

    assign oGENPAD_SELECT  = sel_q;
    assign oGENPAD_DECODED = decoded_q;
    assign oGENPAD_TYPE    = type_q;
    assign oVALID          = valid_q;

endmodule

// File: tb/tb_genesis_gamepads_multi.sv
// tb/tb_genesis_gamepads_multi.sv - directed self-checking bench for genesis_gamepads_multi
module tb_genesis_gamepads_multi;

    localparam int PORTS  = 2;
    localparam int PHASE  = 16;
    localparam int SAMPLE = 6;
    localparam int POLL   = 400;

    logic        iCLK = 1'b0;
    logic        iRESET;
    logic [11:0] iGENPAD;
    logic [1:0]  oGENPAD_SELECT;
    logic [23:0] oGENPAD_DECODED;
    logic [3:0]  oGENPAD_TYPE;
    logic        oVALID;

    genesis_gamepads_multi #(
        .PORTS(PORTS), .PHASE_TICKS(PHASE), .SAMPLE_TICKS(SAMPLE), .POLL_TICKS(POLL)
    ) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iGENPAD(iGENPAD),
        .oGENPAD_SELECT(oGENPAD_SELECT), .oGENPAD_DECODED(oGENPAD_DECODED),
        .oGENPAD_TYPE(oGENPAD_TYPE), .oVALID(oVALID)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pad models: kind 0 = unplugged, 1 = 3-button, 2 = 6-button.
    // btn uses the decoded layout {Z,Y,X,M,S,C,B,A,U,D,L,R}, active high.
    int          kind [2];
    logic [11:0] btn  [2];
    int          edges  = 0;
    int          hi_cnt = 0;
    logic        sel_prev = 1'b1;

    function automatic logic [5:0] pad_pins(input int kd, input logic [11:0] b,
                                            input logic sel, input int k);
        logic [11:0] n;
        n = ~b;
        if (kd == 0) return 6'h3F;
        if (sel) begin
            if (kd == 2 && k == 5) return {n[6], n[5], n[11], n[10], n[9], n[8]};
            return {n[6], n[5], n[3], n[2], n[1], n[0]};
        end
        if (kd == 2 && k == 4) return {n[7], n[4], 4'b0000};
        if (kd == 2 && k == 6) return {n[7], n[4], 4'b1111};
        return {n[7], n[4], n[3], n[2], 2'b00};
    endfunction

    // Phase tracking inside the pad: count SELECT edges, forget after a long high idle.
    always @(posedge iCLK) begin
        sel_prev <= oGENPAD_SELECT[0];
        if (oGENPAD_SELECT[0] && sel_prev) hi_cnt <= hi_cnt + 1;
        else                               hi_cnt <= 0;
        if (oGENPAD_SELECT[0] != sel_prev) edges <= edges + 1;
        else if (hi_cnt > 3 * PHASE)       edges <= 0;
    end

    always_comb begin
        iGENPAD = {pad_pins(kind[1], btn[1], oGENPAD_SELECT[1], edges - 1),
                   pad_pins(kind[0], btn[0], oGENPAD_SELECT[0], edges - 1)};
    end

    task automatic wait_fall(output int n);
        n = 0;
        for (int i = 0; i < 2 * POLL; i++) begin
            @(posedge iCLK); #1;
            n++;
            if (oGENPAD_SELECT[0] == 1'b0) return;
        end
        check("fall_timeout", n, 0);
    endtask

    task automatic wait_valid(output int m);
        m = 0;
        for (int i = 0; i < 2 * POLL; i++) begin
            @(posedge iCLK); #1;
            m++;
            if (oVALID) begin
                @(posedge iCLK); #1;
                check("valid_width", oVALID, 0);
                return;
            end
        end
        check("valid_timeout", m, 0);
    endtask

    initial begin
        int n, m;
        kind[0] = 2; btn[0] = 12'h880;   // 6-button, Z + Start
        kind[1] = 1; btn[1] = 12'h011;   // 3-button, A + Right
        iRESET = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_sel",   oGENPAD_SELECT, 2'b11);
        check("rst_dec",   oGENPAD_DECODED, 24'h0);
        check("rst_type",  oGENPAD_TYPE, 4'h0);
        check("rst_valid", oVALID, 0);
        iRESET = 1'b0;

        wait_fall(n);
        check("first_fall", n, POLL);
        check("sel_low_all", oGENPAD_SELECT, 2'b00);
        wait_valid(m);
        check("valid_latency", m, 8 * PHASE);
        check("b1_dec0", oGENPAD_DECODED[11:0], 12'h880);
        check("b1_dec1", oGENPAD_DECODED[23:12], 12'h011);
        check("b1_type", oGENPAD_TYPE, 4'h0);
        check("b1_sel_idle", oGENPAD_SELECT, 2'b11);

        wait_valid(m);
        check("valid_period", m, POLL - 1);
        check("b2_dec0", oGENPAD_DECODED[11:0], 12'h880);
        check("b2_dec1", oGENPAD_DECODED[23:12], 12'h011);
        check("b2_type", oGENPAD_TYPE, {2'd1, 2'd2});

        kind[1] = 0;   // hot-unplug port 1
        wait_valid(m);
        check("b3_dec1", oGENPAD_DECODED[23:12], 12'h000);
        check("b3_type", oGENPAD_TYPE, {2'd1, 2'd2});
        wait_valid(m);
        check("b4_type", oGENPAD_TYPE, {2'd0, 2'd2});

        kind[0] = 1;   // port 0 becomes a 3-button pad, Z no longer reported
        wait_valid(m);
        check("b5_dec0", oGENPAD_DECODED[11:0], 12'h080);
        check("b5_type", oGENPAD_TYPE, {2'd0, 2'd2});
        wait_valid(m);
        check("b6_type", oGENPAD_TYPE, {2'd0, 2'd1});
        kind[0] = 2;
        wait_valid(m);
        check("b7_dec0", oGENPAD_DECODED[11:0], 12'h880);
        check("b7_type", oGENPAD_TYPE, {2'd0, 2'd1});
        wait_valid(m);
        check("b8_type", oGENPAD_TYPE, {2'd0, 2'd2});

        // Reset in phase 5 of a burst
        wait_fall(n);
        repeat (5 * PHASE + 3) @(posedge iCLK);
        #1;
        iRESET = 1'b1;
        #1;
        check("mid_rst_sel",   oGENPAD_SELECT, 2'b11);
        check("mid_rst_dec",   oGENPAD_DECODED, 24'h0);
        check("mid_rst_type",  oGENPAD_TYPE, 4'h0);
        repeat (4) @(posedge iCLK);
        #1;
        check("mid_rst_valid", oVALID, 0);
        iRESET = 1'b0;
        wait_fall(n);
        check("fall_after_rst", n, POLL);
        wait_valid(m);
        check("r1_dec0", oGENPAD_DECODED[11:0], 12'h880);
        check("r1_type", oGENPAD_TYPE, 4'h0);
        wait_valid(m);
        check("r2_type", oGENPAD_TYPE, {2'd0, 2'd2});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
